// File: rtl/enemy_pkg.sv
// Shared types and screen constants for the enemy controller.
// Holds the state enum, screen/sprite sizes and the coordinate type.
package enemy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    PATROL,
    DYING,
    DEAD,
    DIVE,
    RETURN
  } state_t;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;

  localparam int X_LIMIT = SCREEN_W - SPRITE_W;
  localparam int Y_LIMIT = SCREEN_H - SPRITE_H;

  typedef logic [10:0] coord_t;

endpackage

// File: rtl/enemy_ctl_frame_tick.sv
// Frame tick generator: vsync rising-edge detector plus move-step divider.
// Ports: clk, rst_n, vsync, clr (divider clear) -> tick, step.
module frame_tick #(
  parameter int FRAME_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic clr,
  output logic tick,
  output logic step
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(FRAME_DIV - 1);

  logic          vs_q;
  logic [DW-1:0] div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      tick  <= 1'b0;
      div_q <= '0;
    end else begin
      vs_q <= vsync;
      tick <= vsync & ~vs_q;
      if (clr)
        div_q <= '0;
      else if (tick)
        div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
    end
  end

  assign step = tick & (div_q == LAST);

endmodule

// File: rtl/enemy_ctl.sv
// Per-enemy motion and life-cycle controller feeding the sprite draw stage.
// Ports: pclk, rst (async low), vsync_in, start, hit -> xpos, ypos, on,
// alive, dead_pulse. Define ENEMY_CTL_DIVE_EN to enable the dive feature.
module enemy_ctl
  import enemy_pkg::*;
#(
  parameter int X_START      = 100,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = X_LIMIT,
  parameter int Y_ROW        = 64,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int FRAME_DIV    = 1,
  parameter int DEATH_FRAMES = 32,
  parameter int BLINK_PERIOD = 4
`ifdef ENEMY_CTL_DIVE_EN
  ,
  parameter int DIVE_BOUNCES = 4,
  parameter int Y_DIVE       = 400
`endif
) (
  input  logic   pclk,
  input  logic   rst,
  input  logic   vsync_in,
  input  logic   start,
  input  logic   hit,
  output coord_t xpos,
  output coord_t ypos,
  output logic   on,
  output logic   alive,
  output logic   dead_pulse
);

  state_t      state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  logic        dir_q, dir_d;
  logic        on_q, on_d, alive_q, alive_d, dead_q, dead_d;
  logic [15:0] die_q, die_d;
  logic [7:0]  blink_q, blink_d;
  logic        tick, step, chg;
  logic [11:0] x12, y12, xr, xl, yd;
  logic        at_r, at_l, bounce, enter_done;

`ifdef ENEMY_CTL_DIVE_EN
  logic [7:0]  bnc_q, bnc_d;
  logic [11:0] yu;
  logic        last_bnc, dive_done, ret_done;
`endif

  assign chg = (state_d != state_q);

  frame_tick #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk  (pclk),
    .rst_n(rst),
    .vsync(vsync_in),
    .clr  (chg),
    .tick (tick),
    .step (step)
  );

  // 12-bit arithmetic so edge tests never wrap
  assign x12 = {1'b0, x_q};
  assign y12 = {1'b0, y_q};
  assign xr  = x12 + 12'(SPEED_X);
  assign xl  = x12 - 12'(SPEED_X);
  assign yd  = y12 + 12'(SPEED_Y);

  assign at_r       = xr >= 12'(X_MAX);
  assign at_l       = x12 <= 12'(X_MIN + SPEED_X);
  assign bounce     = dir_q ? at_l : at_r;
  assign enter_done = yd >= 12'(Y_ROW);

`ifdef ENEMY_CTL_DIVE_EN
  assign yu        = y12 - 12'(SPEED_Y);
  assign last_bnc  = bnc_q == 8'(DIVE_BOUNCES - 1);
  assign dive_done = yd >= 12'(Y_DIVE);
  assign ret_done  = y12 <= 12'(Y_ROW + SPEED_Y);
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= coord_t'(X_START);
      y_q     <= '0;
      dir_q   <= 1'b0;
      on_q    <= 1'b0;
      alive_q <= 1'b0;
      dead_q  <= 1'b0;
      die_q   <= '0;
      blink_q <= '0;
`ifdef ENEMY_CTL_DIVE_EN
      bnc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      on_q    <= on_d;
      alive_q <= alive_d;
      dead_q  <= dead_d;
      die_q   <= die_d;
      blink_q <= blink_d;
`ifdef ENEMY_CTL_DIVE_EN
      bnc_q   <= bnc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DEAD:
        if (start) state_d = ENTER;
      ENTER:
        if (step && enter_done) state_d = PATROL;
`ifdef ENEMY_CTL_DIVE_EN
      PATROL:
        if (step && bounce && last_bnc) state_d = DIVE;
      DIVE:
        if (step && dive_done) state_d = RETURN;
      RETURN:
        if (step && ret_done) state_d = PATROL;
`endif
      DYING:
        if (tick && die_q == 16'(DEATH_FRAMES - 1)) state_d = DEAD;
      default: ;
    endcase
    // alive_q is high exactly in the hittable states; hit beats a step
    if (hit && alive_q) state_d = DYING;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    on_d    = on_q;
    alive_d = alive_q;
    dead_d  = 1'b0;
    die_d   = die_q;
    blink_d = blink_q;
`ifdef ENEMY_CTL_DIVE_EN
    bnc_d   = bnc_q;
`endif
    unique case (state_q)
      IDLE, DEAD:
        if (start) begin
          x_d     = coord_t'(X_START);
          y_d     = '0;
          dir_d   = 1'b0;
          on_d    = 1'b1;
          alive_d = 1'b1;
`ifdef ENEMY_CTL_DIVE_EN
          bnc_d   = '0;
`endif
        end
      ENTER:
        if (step) y_d = enter_done ? coord_t'(Y_ROW) : yd[10:0];
      PATROL:
        if (step) begin
          if (bounce) begin
            x_d   = dir_q ? coord_t'(X_MIN) : coord_t'(X_MAX);
            dir_d = ~dir_q;
`ifdef ENEMY_CTL_DIVE_EN
            bnc_d = last_bnc ? '0 : bnc_q + 8'd1;
`endif
          end else begin
            x_d = dir_q ? xl[10:0] : xr[10:0];
          end
        end
`ifdef ENEMY_CTL_DIVE_EN
      DIVE:
        if (step) y_d = dive_done ? coord_t'(Y_DIVE) : yd[10:0];
      RETURN:
        if (step) y_d = ret_done ? coord_t'(Y_ROW) : yu[10:0];
`endif
      DYING:
        if (tick) begin
          if (die_q == 16'(DEATH_FRAMES - 1)) begin
            on_d   = 1'b0;
            dead_d = 1'b1;
            die_d  = '0;
          end else begin
            die_d = die_q + 16'd1;
            if (blink_q == 8'(BLINK_PERIOD - 1)) begin
              blink_d = '0;
              on_d    = ~on_q;
            end else begin
              blink_d = blink_q + 8'd1;
            end
          end
        end
      default: ;
    endcase
    if (hit && alive_q) begin
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      on_d    = 1'b1;
      alive_d = 1'b0;
      die_d   = '0;
      blink_d = '0;
`ifdef ENEMY_CTL_DIVE_EN
      bnc_d   = bnc_q;
`endif
    end
  end

  assign xpos       = x_q;
  assign ypos       = y_q;
  assign on         = on_q;
  assign alive      = alive_q;
  assign dead_pulse = dead_q;

endmodule

// File: tb/tb_enemy_ctl.sv
// Self-checking bench for enemy_ctl against a frame-level reference model.
// Random vsync pulse widths and gaps; directed life-cycle scenarios.
module tb_enemy_ctl;

  localparam int XS = 100, XMIN = 0, XMAX = 960, YROW = 64, SX = 2, SY = 2;
  localparam int DF = 32, BP = 4, NB = 4, YDIVE = 400;
  localparam int S_IDLE = 0, S_ENTER = 1, S_PATROL = 2, S_DYING = 3;
  localparam int S_DEAD = 4, S_DIVE = 5, S_RET = 6;

  logic        clk = 0, rst_n = 0, vsync = 0, start = 0, hit = 0;
  logic [10:0] xpos, ypos;
  logic        on, alive, dead_pulse;

  int vectors = 0, miscompares = 0, dp_seen = 0;
  int m_st, m_x, m_y, m_frames, m_bnc, m_bnc_total;
  bit m_left;

  enemy_ctl dut (
    .pclk(clk), .rst(rst_n), .vsync_in(vsync), .start(start), .hit(hit),
    .xpos(xpos), .ypos(ypos), .on(on), .alive(alive),
    .dead_pulse(dead_pulse)
  );

  always #5 clk = ~clk;

  function automatic bit m_alive();
    return m_st == S_ENTER || m_st == S_PATROL ||
           m_st == S_DIVE || m_st == S_RET;
  endfunction

  function automatic bit m_on();
    if (m_alive()) return 1'b1;
    if (m_st == S_DYING) return ((m_frames / BP) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic void m_reset();
    m_st = S_IDLE; m_x = XS; m_y = 0; m_left = 0;
    m_frames = 0; m_bnc = 0;
  endfunction

  function automatic void m_start();
    if (m_st == S_IDLE || m_st == S_DEAD) begin
      m_st = S_ENTER; m_x = XS; m_y = 0; m_left = 0; m_bnc = 0;
    end
  endfunction

  function automatic void m_hit();
    if (m_alive()) begin m_st = S_DYING; m_frames = 0; end
  endfunction

  function automatic void m_bounce();
    m_bnc++; m_bnc_total++;
`ifdef ENEMY_CTL_DIVE_EN
    if (m_bnc == NB) begin m_bnc = 0; m_st = S_DIVE; end
`endif
  endfunction

  function automatic void m_frame();
    case (m_st)
      S_ENTER: begin
        m_y += SY;
        if (m_y >= YROW) begin m_y = YROW; m_st = S_PATROL; end
      end
      S_PATROL:
        if (!m_left) begin
          if (m_x + SX >= XMAX) begin m_x = XMAX; m_left = 1; m_bounce(); end
          else m_x += SX;
        end else begin
          if (m_x <= XMIN + SX) begin m_x = XMIN; m_left = 0; m_bounce(); end
          else m_x -= SX;
        end
      S_DIVE: begin
        m_y += SY;
        if (m_y >= YDIVE) begin m_y = YDIVE; m_st = S_RET; end
      end
      S_RET: begin
        m_y -= SY;
        if (m_y <= YROW) begin m_y = YROW; m_st = S_PATROL; end
      end
      S_DYING: begin
        m_frames++;
        if (m_frames == DF) m_st = S_DEAD;
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".xpos"}, 32'(xpos), 32'(m_x));
    chk({tag, ".ypos"}, 32'(ypos), 32'(m_y));
    chk({tag, ".on"}, 32'(on), 32'(m_on()));
    chk({tag, ".alive"}, 32'(alive), 32'(m_alive()));
  endtask

  task automatic pulse(input bit with_hit);
    int h, l, prev;
    bit dp_exp;
    h = $urandom_range(1, 3);
    l = $urandom_range(2, 4);
    dp_seen = 0;
    vsync = 1;
    @(negedge clk);
    if (dead_pulse) dp_seen++;
    hit = with_hit;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      hit = 0;
      if (dead_pulse) dp_seen++;
    end
    vsync = 0;
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      if (dead_pulse) dp_seen++;
    end
    dp_exp = 0;
    if (with_hit && m_alive()) m_hit();
    else begin
      prev = m_st;
      m_frame();
      dp_exp = (prev == S_DYING && m_st == S_DEAD);
      if (with_hit) m_hit();
    end
    chk("dead_pulse_cycles", 32'(dp_seen), 32'(dp_exp));
    chk_all("frame");
  endtask

  task automatic do_start(input bit with_hit);
    bit taken;
    start = 1; hit = with_hit;
    @(negedge clk);
    start = 0; hit = 0;
    @(negedge clk);
    taken = (m_st == S_IDLE || m_st == S_DEAD);
    m_start();
    if (!taken && with_hit) m_hit();
    chk_all("start");
  endtask

  initial begin
    int n, max_y;
    m_bnc_total = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst.xpos", 32'(xpos), 32'(XS));
    chk("rst.ypos", 32'(ypos), 32'd0);
    chk("rst.on", 32'(on), 32'd0);
    chk("rst.alive", 32'(alive), 32'd0);
    chk("rst.dead_pulse", 32'(dead_pulse), 32'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) pulse(i == 4);

    do_start(0);
    chk("spawn.alive", 32'(alive), 32'd1);
    for (int i = 0; i < 32; i++) begin
      pulse(0);
      chk("enter.ypos", 32'(ypos), 32'(2 * (i + 1)));
    end
    pulse(0);
    chk("patrol1.xpos", 32'(xpos), 32'd102);
    chk("patrol1.ypos", 32'(ypos), 32'd64);

    for (int i = 0; i < 429; i++) begin
      pulse(0);
      if (i % 100 == 50) do_start(0);
    end
    chk("right_edge.xpos", 32'(xpos), 32'd960);
    pulse(0);
    chk("right_edge.next", 32'(xpos), 32'd958);

    n = 0;
    while (!(m_x == 2 && m_left) && n < 600) begin
      pulse(0);
      n++;
    end
    chk("left_edge.pre", 32'(xpos), 32'd2);
    pulse(0);
    chk("left_edge.xpos", 32'(xpos), 32'd0);
    pulse(0);
    chk("left_edge.next", 32'(xpos), 32'd2);

    max_y = 0;
    n = 0;
    while (!(m_bnc_total >= 4 && m_st == S_PATROL) && n < 3000) begin
      pulse(0);
      if (int'(ypos) > max_y) max_y = int'(ypos);
      n++;
    end
`ifdef ENEMY_CTL_DIVE_EN
    chk("dive.peak", 32'(max_y), 32'(YDIVE));
`else
    chk("nodive.peak", 32'(max_y), 32'(YROW));
`endif
    chk("after_bounces.ypos", 32'(ypos), 32'(YROW));

    n = 0;
    while (!(m_x == 120 && !m_left && m_st == S_PATROL) && n < 600) begin
      pulse(0);
      n++;
    end
    pulse(1);
    chk("hit.xpos", 32'(xpos), 32'd120);
    chk("hit.alive", 32'(alive), 32'd0);
    for (int i = 0; i < 32; i++) pulse(i == 9);
    chk("dead.on", 32'(on), 32'd0);
    chk("dead.xpos", 32'(xpos), 32'd120);

    do_start(1);
    chk("respawn.xpos", 32'(xpos), 32'(XS));
    chk("respawn.ypos", 32'(ypos), 32'd0);
    chk("respawn.alive", 32'(alive), 32'd1);
    for (int i = 0; i < 5; i++) pulse(0);
    pulse(1);
    for (int i = 0; i < 5; i++) pulse(0);

    rst_n = 0;
    #1;
    m_reset();
    chk("async_rst.on", 32'(on), 32'd0);
    chk("async_rst.alive", 32'(alive), 32'd0);
    chk("async_rst.xpos", 32'(xpos), 32'(XS));
    chk("async_rst.ypos", 32'(ypos), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) pulse(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
